// File: rtl/paicore_send_sched.sv
// paicore_send_sched
//   Frame sequencer for the PAICORE downstream send path. Accepts a host
//   command (frame count, words per frame, watchdog limit), drives send_len,
//   opens the upstream AXI-Stream gate one frame at a time and waits for the
//   transport to report each frame complete before arming the next one.
//
// Ports
//   s_axis_aclk / s_axis_areset : clock, synchronous active-high reset
//   cfg_start, cfg_abort        : start pulse (IDLE only), abort request
//   cfg_frame_num/send_len/timeout : command fields (0 frames/words illegal,
//                                 timeout 0 disables the watchdog)
//   send_len, dp_enable         : datapath length and upstream gate
//   write_hsked, snn_in_hsked   : word accepted / word consumed strobes
//   o_tx_done                   : transport finished a frame (input pulse)
//   busy, done, err, err_code   : status (err_code 0 cfg,1 abort,2 timeout,3 mismatch)
//   frame_cnt, in_word_cnt, out_word_cnt : progress counters (saturating)
module paicore_send_sched #(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned LEN_W   = 32
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_areset,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [FRAME_W-1:0] cfg_frame_num,
  input  logic [LEN_W-1:0]   cfg_send_len,
  input  logic [31:0]        cfg_timeout,
  output logic [LEN_W-1:0]   send_len,
  output logic               dp_enable,
  input  logic               write_hsked,
  input  logic               snn_in_hsked,
  input  logic               o_tx_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [LEN_W-1:0]   in_word_cnt,
  output logic [LEN_W-1:0]   out_word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    E_CFG = 2'd0, E_ABORT = 2'd1, E_TIMEOUT = 2'd2, E_MISMATCH = 2'd3
  } err_t;

  state_t             r_state;
  logic [FRAME_W-1:0] r_frame_num;
  logic [31:0]        r_timeout;
  logic [31:0]        r_wdog;

  logic [LEN_W-1:0]   w_in_next;
  logic [LEN_W-1:0]   w_out_next;
  logic [FRAME_W-1:0] w_frame_next;
  logic [31:0]        w_wdog_next;
  logic               w_in_last;
  logic               w_timeout;
  logic               w_cfg_ok;

  always_comb begin
    w_in_next    = (write_hsked && in_word_cnt != '1) ? in_word_cnt + LEN_W'(1) : in_word_cnt;
    w_out_next   = (snn_in_hsked && out_word_cnt != '1) ? out_word_cnt + LEN_W'(1) : out_word_cnt;
    w_frame_next = (frame_cnt != '1) ? frame_cnt + FRAME_W'(1) : frame_cnt;
    // Watchdog counts idle cycles including the current one, so a match
    // fires on the Nth consecutive cycle without any handshake.
    if (write_hsked || snn_in_hsked)
      w_wdog_next = '0;
    else
      w_wdog_next = (r_wdog != '1) ? r_wdog + 32'd1 : r_wdog;
    w_in_last    = write_hsked && (in_word_cnt == send_len - LEN_W'(1));
    w_timeout    = (r_timeout != '0) && (w_wdog_next == r_timeout);
    w_cfg_ok     = (cfg_frame_num != '0) && (cfg_send_len != '0);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_state      <= S_IDLE;
      r_frame_num  <= '0;
      r_timeout    <= '0;
      r_wdog       <= '0;
      send_len     <= '0;
      dp_enable    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= '0;
      frame_cnt    <= '0;
      in_word_cnt  <= '0;
      out_word_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            if (w_cfg_ok) begin
              r_frame_num <= cfg_frame_num;
              r_timeout   <= cfg_timeout;
              send_len    <= cfg_send_len;
              err         <= 1'b0;
              err_code    <= '0;
              frame_cnt   <= '0;
              busy        <= 1'b1;
              r_state     <= S_ARM;
            end else begin
              err      <= 1'b1;
              err_code <= E_CFG;
            end
          end
        end
        S_ARM: begin
          in_word_cnt  <= '0;
          out_word_cnt <= '0;
          r_wdog       <= '0;
          if (cfg_abort) begin
            err      <= 1'b1;
            err_code <= E_ABORT;
            r_state  <= S_ERR;
          end else begin
            dp_enable <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          in_word_cnt  <= w_in_next;
          out_word_cnt <= w_out_next;
          r_wdog       <= w_wdog_next;
          if (cfg_abort || o_tx_done || w_timeout) begin
            dp_enable <= 1'b0;
            err       <= 1'b1;
            r_state   <= S_ERR;
            if (cfg_abort)      err_code <= E_ABORT;
            else if (o_tx_done) err_code <= E_MISMATCH;
            else                err_code <= E_TIMEOUT;
          end else if (w_in_last) begin
            dp_enable <= 1'b0;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          out_word_cnt <= w_out_next;
          r_wdog       <= w_wdog_next;
          if (cfg_abort) begin
            err      <= 1'b1;
            err_code <= E_ABORT;
            r_state  <= S_ERR;
          end else if (o_tx_done && w_out_next != send_len) begin
            err      <= 1'b1;
            err_code <= E_MISMATCH;
            r_state  <= S_ERR;
          end else if (w_timeout) begin
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
            r_state  <= S_ERR;
          end else if (o_tx_done) begin
            frame_cnt <= w_frame_next;
            if (w_frame_next == r_frame_num) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_ERR: begin
          dp_enable <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
